// File: rtl/burst_main_memory_pkg.sv
// Shared definitions for the burst main memory: write size codes, FSM state
// encoding and beat-owner codes.
package burst_main_memory_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2
  } state_e;

  localparam logic [2:0] SZ_ONE_BYTE   = 3'd0;
  localparam logic [2:0] SZ_TWO_BYTE   = 3'd1;
  localparam logic [2:0] SZ_FOUR_BYTE  = 3'd2;
  localparam logic [2:0] SZ_EIGHT_BYTE = 3'd3;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  // Bytes committed per write beat; an eight-byte store goes out as two
  // four-byte beats, and unknown codes commit nothing.
  function automatic logic [3:0] size_bytes(input logic [2:0] code);
    case (code)
      SZ_ONE_BYTE:   size_bytes = 4'd1;
      SZ_TWO_BYTE:   size_bytes = 4'd2;
      SZ_FOUR_BYTE:  size_bytes = 4'd4;
      SZ_EIGHT_BYTE: size_bytes = 4'd4;
      default:       size_bytes = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/burst_main_memory_if.sv
// Host-side bus of the burst main memory: instruction read channel, data
// read/write channel and the shared read-return / write-beat signals.
interface burst_main_memory_if #(
  parameter int ADDR_WIDTH       = 20,
  parameter int DATA_LEN         = 32,
  parameter int ENTRY_INDEX_SIZE = 3
);

  // Handshake: a request is taken in the cycle its *_req_ready is high while
  // *_req_valid is high; the host holds valid and all request fields stable
  // until then. Ready is a one-cycle pulse. d_wbeat_ack high means d_wdata is
  // consumed at the end of that cycle; the next beat is presented after it.
  logic                        i_req_valid;
  logic [ADDR_WIDTH-1:0]       i_req_addr;
  logic [ENTRY_INDEX_SIZE:0]   i_req_len;
  logic                        i_req_ready;

  logic                        d_req_valid;
  logic                        d_req_write;
  logic [ADDR_WIDTH-1:0]       d_req_addr;
  logic [ENTRY_INDEX_SIZE:0]   d_req_len;
  logic [2:0]                  d_req_type;
  logic                        d_req_ready;
  logic [DATA_LEN-1:0]         d_wdata;
  logic                        d_wbeat_ack;

  logic [DATA_LEN-1:0]         rdata;
  logic                        rdata_valid;
  logic                        rdata_last;
  logic                        rdata_owner;
  logic                        wr_done;

  modport master (
    output i_req_valid, i_req_addr, i_req_len,
    output d_req_valid, d_req_write, d_req_addr, d_req_len, d_req_type, d_wdata,
    input  i_req_ready, d_req_ready, d_wbeat_ack,
    input  rdata, rdata_valid, rdata_last, rdata_owner, wr_done
  );

  modport slave (
    input  i_req_valid, i_req_addr, i_req_len,
    input  d_req_valid, d_req_write, d_req_addr, d_req_len, d_req_type, d_wdata,
    output i_req_ready, d_req_ready, d_wbeat_ack,
    output rdata, rdata_valid, rdata_last, rdata_owner, wr_done
  );

endinterface

// File: rtl/mem_arbiter.sv
// Fixed data-over-instruction arbiter with a saturating starvation counter
// that hands one grant to the instruction channel after STARVE_LIMIT data wins.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                arb_en,
  input  logic                                i_valid,
  input  logic                                d_valid,
  output logic                                grant,
  output logic                                grant_inst,
  output logic [$clog2(STARVE_LIMIT+1)-1:0]   starve_cnt
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

  logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
  logic            starved;

  assign starved    = (starve_cnt_q == SC_MAX);
  assign grant      = arb_en && (i_valid || d_valid);
  assign grant_inst = arb_en && i_valid && (!d_valid || starved);
  assign starve_cnt = starve_cnt_q;

  // Only data wins that actually bypass a waiting instruction request count.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant) begin
      if (grant_inst)
        starve_cnt_d = '0;
      else if (i_valid && !starved)
        starve_cnt_d = starve_cnt_q + SC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/burst_main_memory.sv
// Byte-addressed burst memory with one burst in flight: IDLE arbitrates,
// WAIT models access latency, XFER streams one beat per cycle.
module burst_main_memory
  import burst_main_memory_pkg::*;
#(
  parameter int ADDR_WIDTH       = 20,
  parameter int DATA_LEN         = 32,
  parameter int BYTE_SIZE        = 8,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int LATENCY          = 2,
  parameter int STARVE_LIMIT     = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  burst_main_memory_if.slave                  bus,
  output state_e                              dbg_state,
  output logic [$clog2(STARVE_LIMIT+1)-1:0]   dbg_starve_cnt
);

  localparam int BPB   = DATA_LEN / BYTE_SIZE;
  localparam int LEN_W = ENTRY_INDEX_SIZE + 1;
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  // Storage has no reset so contents survive rst_n.
  logic [BYTE_SIZE-1:0] storage_q [2**ADDR_WIDTH];

  state_e                state_q, state_d;
  logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
  logic [LEN_W-1:0]      beat_q, beat_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            type_q, type_d;
  logic                  write_q, write_d;
  logic                  owner_q, owner_d;
  logic                  i_ready_q, i_ready_d;
  logic                  d_ready_q, d_ready_d;
  logic [DATA_LEN-1:0]   rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic                  rowner_q, rowner_d;
  logic                  wack_q, wack_d;
  logic                  wr_done_q, wr_done_d;

  logic                  grant, grant_inst;
  logic                  wr_en, beat_go;
  logic [ADDR_WIDTH-1:0] addr_next, beat_addr;
  logic [DATA_LEN-1:0]   rd_word;
  logic [3:0]            wr_nbytes;

  mem_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .arb_en     (state_q == S_IDLE),
    .i_valid    (bus.i_req_valid),
    .d_valid    (bus.d_req_valid),
    .grant      (grant),
    .grant_inst (grant_inst),
    .starve_cnt (dbg_starve_cnt)
  );

  assign addr_next = addr_q + ADDR_WIDTH'(BPB);
  assign wr_nbytes = size_bytes(type_q);

  // Beat data is fetched one cycle ahead so rdata leaves a flop.
  always_comb begin
    beat_addr = (state_q == S_XFER) ? addr_next : addr_q;
    rd_word   = '0;
    for (int k = 0; k < BPB; k++)
      rd_word[DATA_LEN-1-k*BYTE_SIZE -: BYTE_SIZE] = storage_q[beat_addr + ADDR_WIDTH'(k)];
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    beat_d    = beat_q;
    len_d     = len_q;
    addr_d    = addr_q;
    type_d    = type_q;
    write_d   = write_q;
    owner_d   = owner_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    rlast_d   = 1'b0;
    rowner_d  = rowner_q;
    wack_d    = 1'b0;
    wr_done_d = 1'b0;
    wr_en     = 1'b0;
    beat_go   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d   = S_WAIT;
          lat_cnt_d = LAT_W'(LATENCY - 1);
          beat_d    = '0;
          if (grant_inst) begin
            addr_d    = bus.i_req_addr;
            len_d     = (bus.i_req_len == '0) ? LEN_W'(1) : bus.i_req_len;
            type_d    = SZ_FOUR_BYTE;
            write_d   = 1'b0;
            owner_d   = OWNER_INST;
            i_ready_d = 1'b1;
          end else begin
            addr_d    = bus.d_req_addr;
            type_d    = bus.d_req_type;
            write_d   = bus.d_req_write;
            owner_d   = OWNER_DATA;
            d_ready_d = 1'b1;
            if (bus.d_req_write && bus.d_req_type == SZ_EIGHT_BYTE)
              len_d = LEN_W'(2);
            else
              len_d = (bus.d_req_len == '0) ? LEN_W'(1) : bus.d_req_len;
          end
        end
      end
      S_WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d = S_XFER;
          beat_go = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      S_XFER: begin
        wr_en = write_q;
        if (beat_q == len_q - LEN_W'(1)) begin
          state_d   = S_IDLE;
          wr_done_d = write_q;
        end else begin
          beat_d  = beat_q + LEN_W'(1);
          addr_d  = addr_next;
          beat_go = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (beat_go) begin
      if (write_q) begin
        wack_d = 1'b1;
      end else begin
        rvalid_d = 1'b1;
        rdata_d  = rd_word;
        rlast_d  = (beat_d == len_q - LEN_W'(1));
        rowner_d = owner_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lat_cnt_q <= '0;
      beat_q    <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      type_q    <= '0;
      write_q   <= 1'b0;
      owner_q   <= OWNER_INST;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rowner_q  <= OWNER_INST;
      wack_q    <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      beat_q    <= beat_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      type_q    <= type_d;
      write_q   <= write_d;
      owner_q   <= owner_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rowner_q  <= rowner_d;
      wack_q    <= wack_d;
      wr_done_q <= wr_done_d;
    end
  end

  // Write beat commits the top wr_nbytes bytes of d_wdata, wrapping the address.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < BPB; k++) begin
        if (k < int'(wr_nbytes))
          storage_q[addr_q + ADDR_WIDTH'(k)] <= bus.d_wdata[DATA_LEN-1-k*BYTE_SIZE -: BYTE_SIZE];
      end
    end
  end

  assign bus.i_req_ready = i_ready_q;
  assign bus.d_req_ready = d_ready_q;
  assign bus.d_wbeat_ack = wack_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rvalid_q;
  assign bus.rdata_last  = rlast_q;
  assign bus.rdata_owner = rowner_q;
  assign bus.wr_done     = wr_done_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_burst_main_memory.sv
// Directed bench for burst_main_memory: latency, arbitration/starvation,
// write sizes, address wrap and asynchronous reset behaviour.
module tb_burst_main_memory;
  import burst_main_memory_pkg::*;

  localparam int AW  = 20;
  localparam int DW  = 32;
  localparam int BS  = 8;
  localparam int EIS = 3;
  localparam int LAT = 2;
  localparam int SL  = 4;

  logic       clk;
  logic       rst_n;
  state_e     dbg_state;
  logic [2:0] dbg_starve_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] wv [4];
  logic [1:0]    exp_q [$];

  burst_main_memory_if #(.ADDR_WIDTH(AW), .DATA_LEN(DW), .ENTRY_INDEX_SIZE(EIS)) bus ();

  burst_main_memory #(
    .ADDR_WIDTH(AW), .DATA_LEN(DW), .BYTE_SIZE(BS),
    .ENTRY_INDEX_SIZE(EIS), .LATENCY(LAT), .STARVE_LIMIT(SL)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .dbg_state      (dbg_state),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic own, input logic wr, input logic [AW-1:0] a,
                         input logic [EIS:0] len, input logic [2:0] ty, input string tag);
    int   waited;
    logic rdy;
    waited = 0;
    if (own == OWNER_INST) begin
      bus.i_req_valid = 1'b1;
      bus.i_req_addr  = a;
      bus.i_req_len   = len;
    end else begin
      bus.d_req_valid = 1'b1;
      bus.d_req_write = wr;
      bus.d_req_addr  = a;
      bus.d_req_len   = len;
      bus.d_req_type  = ty;
    end
    do begin
      tick();
      waited++;
      rdy = (own == OWNER_INST) ? bus.i_req_ready : bus.d_req_ready;
    end while (!rdy && waited < 50);
    check({tag, "_ready"}, rdy, 1'b1);
    check({tag, "_ready_lat"}, waited, 1);
    bus.i_req_valid = 1'b0;
    bus.d_req_valid = 1'b0;
  endtask

  task automatic read_burst(input logic own, input logic [AW-1:0] a, input logic [EIS:0] len,
                            input int nbeats, input string tag);
    request(own, 1'b0, a, len, SZ_FOUR_BYTE, tag);
    for (int c = 1; c < LAT; c++) begin
      tick();
      check({tag, "_early"}, bus.rdata_valid, 1'b0);
    end
    for (int i = 0; i < nbeats; i++) begin
      tick();
      check({tag, "_valid"}, bus.rdata_valid, 1'b1);
      check({tag, "_data"}, bus.rdata, wv[i]);
      check({tag, "_last"}, bus.rdata_last, (i == nbeats - 1));
      check({tag, "_owner"}, bus.rdata_owner, own);
    end
    tick();
    check({tag, "_end"}, bus.rdata_valid, 1'b0);
    check({tag, "_hold"}, bus.rdata, wv[nbeats-1]);
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input logic [EIS:0] len, input logic [2:0] ty,
                             input int nbeats, input string tag);
    request(OWNER_DATA, 1'b1, a, len, ty, tag);
    bus.d_wdata = wv[0];
    for (int c = 1; c < LAT; c++) begin
      tick();
      check({tag, "_early_ack"}, bus.d_wbeat_ack, 1'b0);
    end
    for (int i = 0; i < nbeats; i++) begin
      tick();
      if (i > 0) bus.d_wdata = wv[i];
      check({tag, "_ack"}, bus.d_wbeat_ack, 1'b1);
      check({tag, "_done_early"}, bus.wr_done, 1'b0);
    end
    tick();
    check({tag, "_ack_end"}, bus.d_wbeat_ack, 1'b0);
    check({tag, "_wr_done"}, bus.wr_done, 1'b1);
    tick();
    check({tag, "_wr_done_pulse"}, bus.wr_done, 1'b0);
  endtask

  initial begin
    int ng;
    int cyc;
    logic [1:0] g;

    rst_n           = 1'b0;
    bus.i_req_valid = 1'b0;
    bus.i_req_addr  = '0;
    bus.i_req_len   = '0;
    bus.d_req_valid = 1'b1;
    bus.d_req_write = 1'b0;
    bus.d_req_addr  = '0;
    bus.d_req_len   = '0;
    bus.d_req_type  = '0;
    bus.d_wdata     = '0;

    // Reset state, with a request pending that must be ignored
    tick();
    tick();
    check("rst_d_ready", bus.d_req_ready, 1'b0);
    check("rst_i_ready", bus.i_req_ready, 1'b0);
    check("rst_rvalid", bus.rdata_valid, 1'b0);
    check("rst_rlast", bus.rdata_last, 1'b0);
    check("rst_ack", bus.d_wbeat_ack, 1'b0);
    check("rst_wr_done", bus.wr_done, 1'b0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_state", dbg_state, S_IDLE);
    check("rst_starve", dbg_starve_cnt, 3'd0);
    bus.d_req_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Load image bytes 00..0F at 0x100
    wv[0] = 32'h00010203; wv[1] = 32'h04050607; wv[2] = 32'h08090A0B; wv[3] = 32'h0C0D0E0F;
    write_burst(20'h00100, 4'd4, SZ_FOUR_BYTE, 4, "img");

    // Data read len 4 at 0x100
    read_burst(OWNER_DATA, 20'h00100, 4'd4, 4, "rd4");

    // Instruction len 0 -> one beat
    wv[0] = 32'h04050607;
    read_burst(OWNER_INST, 20'h00104, 4'd0, 1, "ilen0");

    // Eight-byte write: len field ignored, two beats
    wv[0] = 32'hAABBCCDD; wv[1] = 32'h11223344;
    write_burst(20'h00200, 4'd7, SZ_EIGHT_BYTE, 2, "w8");
    read_burst(OWNER_DATA, 20'h00200, 4'd2, 2, "rd8");

    // Address wrap within and across beats
    wv[0] = 32'hA1A2A3A4; wv[1] = 32'hB1B2B3B4;
    write_burst(20'hFFFFE, 4'd2, SZ_FOUR_BYTE, 2, "wwrap");
    read_burst(OWNER_DATA, 20'hFFFFE, 4'd2, 2, "rwrap");
    wv[0] = 32'hA3A4B1B2;
    read_burst(OWNER_INST, 20'h00000, 4'd1, 1, "rwrap0");

    // Both channels valid every cycle: D,D,D,D,I,D
    exp_q.push_back(2'b01); exp_q.push_back(2'b01); exp_q.push_back(2'b01);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10); exp_q.push_back(2'b01);
    bus.i_req_valid = 1'b1; bus.i_req_addr = 20'h00100; bus.i_req_len = 4'd1;
    bus.d_req_valid = 1'b1; bus.d_req_write = 1'b0; bus.d_req_addr = 20'h00104;
    bus.d_req_len = 4'd1; bus.d_req_type = SZ_FOUR_BYTE;
    ng = 0;
    cyc = 0;
    while (ng < 6 && cyc < 200) begin
      tick();
      cyc++;
      g = {bus.i_req_ready, bus.d_req_ready};
      if (g != 2'b00) begin
        check($sformatf("starve_grant%0d", ng), g, exp_q.pop_front());
        if (ng == 3) check("starve_sat", dbg_starve_cnt, 3'd4);
        if (ng == 4) check("starve_clr", dbg_starve_cnt, 3'd0);
        ng++;
      end
    end
    check("starve_grants", ng, 6);
    bus.i_req_valid = 1'b0;
    bus.d_req_valid = 1'b0;
    cyc = 0;
    while (dbg_state != S_IDLE && cyc < 20) begin
      tick();
      cyc++;
    end
    check("starve_idle", dbg_state, S_IDLE);
    tick();

    // Reset during beat 2 of a 4-beat read
    request(OWNER_DATA, 1'b0, 20'h00100, 4'd4, SZ_FOUR_BYTE, "rstrd");
    for (int c = 0; c < LAT + 1; c++) tick();
    check("rstrd_beat1_valid", bus.rdata_valid, 1'b1);
    check("rstrd_beat1_data", bus.rdata, 32'h04050607);
    rst_n = 1'b0;
    #1;
    check("rstrd_async_valid", bus.rdata_valid, 1'b0);
    check("rstrd_async_rdata", bus.rdata, 32'h0);
    check("rstrd_async_state", dbg_state, S_IDLE);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rstrd_idle", dbg_state, S_IDLE);
    check("rstrd_quiet", bus.rdata_valid, 1'b0);
    wv[0] = 32'h00010203;
    read_burst(OWNER_DATA, 20'h00100, 4'd1, 1, "post_rst");

    // Reset after two committed beats of a 4-beat write
    request(OWNER_DATA, 1'b1, 20'h00300, 4'd4, SZ_FOUR_BYTE, "rstwr");
    bus.d_wdata = 32'h31313131;
    for (int c = 0; c < LAT; c++) tick();
    check("rstwr_ack0", bus.d_wbeat_ack, 1'b1);
    tick();
    bus.d_wdata = 32'h32323232;
    check("rstwr_ack1", bus.d_wbeat_ack, 1'b1);
    tick();
    bus.d_wdata = 32'h33333333;
    rst_n = 1'b0;
    #1;
    check("rstwr_async_ack", bus.d_wbeat_ack, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    wv[0] = 32'h31313131; wv[1] = 32'h32323232;
    read_burst(OWNER_DATA, 20'h00300, 4'd2, 2, "rstwr_kept");

    // Partial and undefined write sizes
    wv[0] = 32'h99887766;
    write_burst(20'h00104, 4'd1, SZ_ONE_BYTE, 1, "w1b");
    wv[0] = 32'h99050607;
    read_burst(OWNER_DATA, 20'h00104, 4'd1, 1, "r1b");
    wv[0] = 32'h77665544;
    write_burst(20'h00108, 4'd1, SZ_TWO_BYTE, 1, "w2b");
    wv[0] = 32'h77660A0B;
    read_burst(OWNER_DATA, 20'h00108, 4'd1, 1, "r2b");
    wv[0] = 32'hFFFFFFFF;
    write_burst(20'h0010C, 4'd1, 3'd5, 1, "wund");
    wv[0] = 32'h0C0D0E0F;
    read_burst(OWNER_DATA, 20'h0010C, 4'd1, 1, "rund");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
